// File: rtl/cpu_mode_loader_if.sv
// Loader-side memory port: address, write strobe/data, read enable and
// read data, plus the ownership select that hands the port to the CPU.
interface cpu_mode_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              mem_sel;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_we;
  logic              ld_re;
  logic [DATA_W-1:0] ld_rdata;

  modport master (
    output mem_sel,
    output ld_addr,
    output ld_wdata,
    output ld_we,
    output ld_re,
    input  ld_rdata
  );

  modport slave (
    input  mem_sel,
    input  ld_addr,
    input  ld_wdata,
    input  ld_we,
    input  ld_re,
    output ld_rdata
  );
endinterface

// File: rtl/cpu_mode_loader.sv
// Front-panel mode sequencer and program loader (IDLE/IN/CHECK/RUN).
// Define LOADER_CHECKSUM_EN to build the running checksum of loaded bytes.
module cpu_mode_loader #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_btn,
  input  logic              step_btn,
  input  logic [DATA_W-1:0] sw_data,
  output logic [1:0]        cpu_state,
  output logic [DATA_W-1:0] disp_data,
  output logic [DATA_W-1:0] chksum,
  cpu_mode_loader_if.master mem
);

  localparam int CNT_W = (DEBOUNCE_CYC < 2) ? 1
                       : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TOP =
    CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_IN    = 2'b01,
    S_CHECK = 2'b10,
    S_RUN   = 2'b11
  } state_e;

  // Bit 0 is the mode button, bit 1 the step button.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] lvl_q;
  logic [1:0] lvl_d;
  logic [1:0] pulse_q;
  logic [1:0] pulse_d;
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;

  assign btn_raw = {step_btn, mode_btn};

  always_comb begin
    lvl_d   = lvl_q;
    pulse_d = '0;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_TOP) begin
          lvl_d[i]   = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  logic mode_p;
  logic step_p;

  // A mode press wins over a simultaneous step press.
  assign mode_p = pulse_q[0];
  assign step_p = pulse_q[1] & ~pulse_q[0];

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic              we_q;
  logic              we_d;
  logic [DATA_W-1:0] disp_q;
  logic [DATA_W-1:0] disp_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    disp_d  = disp_q;
    // A pending write always completes and advances the address.
    if (we_q) begin
      addr_d = addr_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (mode_p) begin
          state_d = S_IN;
          addr_d  = '0;
        end
      end
      S_IN: begin
        if (mode_p) begin
          state_d = S_CHECK;
          addr_d  = '0;
        end else if (step_p) begin
          wdata_d = sw_data;
          we_d    = 1'b1;
        end
      end
      S_CHECK: begin
        disp_d = mem.ld_rdata;
        if (mode_p) begin
          state_d = S_RUN;
        end else if (step_p) begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_RUN: begin
        if (mode_p) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      disp_q  <= disp_d;
    end
  end

  assign cpu_state    = state_q;
  assign disp_data    = disp_q;
  assign mem.mem_sel  = (state_q != S_RUN);
  assign mem.ld_re    = (state_q == S_CHECK);
  assign mem.ld_we    = we_q;
  assign mem.ld_addr  = addr_q;
  assign mem.ld_wdata = wdata_q;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;
  logic [DATA_W-1:0] chk_d;
  logic              chk_clr;

  assign chk_clr = (state_q == S_IDLE) & mode_p;

  always_comb begin
    chk_d = chk_q;
    if (chk_clr) begin
      chk_d = '0;
    end else if (we_q) begin
      chk_d = chk_q + wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign chksum = chk_q;
`else
  assign chksum = '0;
`endif

endmodule

// File: tb/tb_cpu_mode_loader.sv
// Directed bench for cpu_mode_loader: a 16-bit and a 4-bit address
// instance share all stimulus; each has its own memory model.
module tb_cpu_mode_loader;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       mode_btn = 1'b0;
  logic       step_btn = 1'b0;
  logic [7:0] sw_data  = 8'h00;

  logic [1:0] st_a;
  logic [1:0] st_b;
  logic [7:0] disp_a;
  logic [7:0] disp_b;
  logic [7:0] chk_a;
  logic [7:0] chk_b;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [7:0] CHK_LOAD = 8'hEB;
  localparam logic [7:0] CHK_WRAP = 8'h88;
`else
  localparam logic [7:0] CHK_LOAD = 8'h00;
  localparam logic [7:0] CHK_WRAP = 8'h00;
`endif

  cpu_mode_loader_if #(.ADDR_W(16), .DATA_W(8)) ifa ();
  cpu_mode_loader_if #(.ADDR_W(4),  .DATA_W(8)) ifb ();

  cpu_mode_loader #(
    .ADDR_W(16), .DATA_W(8), .DEBOUNCE_CYC(4)
  ) dut_a (
    .clk(clk), .reset(reset),
    .mode_btn(mode_btn), .step_btn(step_btn),
    .sw_data(sw_data), .cpu_state(st_a),
    .disp_data(disp_a), .chksum(chk_a),
    .mem(ifa)
  );

  cpu_mode_loader #(
    .ADDR_W(4), .DATA_W(8), .DEBOUNCE_CYC(4)
  ) dut_b (
    .clk(clk), .reset(reset),
    .mode_btn(mode_btn), .step_btn(step_btn),
    .sw_data(sw_data), .cpu_state(st_b),
    .disp_data(disp_b), .chksum(chk_b),
    .mem(ifb)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [16];
  int wcnt_a = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 16; i++)  mem_b[i] = 8'h00;
  end

  assign ifa.ld_rdata = mem_a[ifa.ld_addr[7:0]];
  assign ifb.ld_rdata = mem_b[ifb.ld_addr];

  always @(posedge clk) begin
    if (ifa.ld_we && ifa.mem_sel) begin
      mem_a[ifa.ld_addr[7:0]] <= ifa.ld_wdata;
      wcnt_a <= wcnt_a + 1;
    end
    if (ifb.ld_we && ifb.mem_sel) begin
      mem_b[ifb.ld_addr] <= ifb.ld_wdata;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic m, logic s, int hold);
    mode_btn = m;
    step_btn = s;
    tick(hold);
    mode_btn = 1'b0;
    step_btn = 1'b0;
    tick(12);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    tick(3);
    chk("rst_state", st_a, 0);
    chk("rst_memsel", ifa.mem_sel, 1);
    chk("rst_addr", ifa.ld_addr, 0);
    chk("rst_we", ifa.ld_we, 0);
    chk("rst_re", ifa.ld_re, 0);
    chk("rst_disp", disp_a, 0);
    chk("rst_chksum", chk_a, 0);
    reset = 1'b1;
    tick(10);
    chk("idle_state", st_a, 0);
    chk("idle_addr", ifa.ld_addr, 0);
    chk("idle_we", ifa.ld_we, 0);
    chk("idle_memsel", ifa.mem_sel, 1);

    press(1'b1, 1'b0, 8);
    chk("in_state", st_a, 1);
    chk("in_re", ifa.ld_re, 0);
    chk("in_memsel", ifa.mem_sel, 1);
    chk("in_addr0", ifa.ld_addr, 0);

    sw_data  = 8'h12;
    step_btn = 1'b1;
    tick(6);
    chk("wr0_pre_we", ifa.ld_we, 0);
    tick(1);
    chk("wr0_we", ifa.ld_we, 1);
    chk("wr0_addr", ifa.ld_addr, 0);
    chk("wr0_data", ifa.ld_wdata, 8'h12);
    tick(1);
    chk("wr0_post_we", ifa.ld_we, 0);
    chk("wr0_inc", ifa.ld_addr, 1);
    step_btn = 1'b0;
    tick(12);
    sw_data = 8'h34;
    press(1'b0, 1'b1, 8);
    sw_data = 8'hA5;
    press(1'b0, 1'b1, 8);
    chk("in_wcnt", wcnt_a, 3);
    chk("in_mem0", mem_a[0], 8'h12);
    chk("in_mem1", mem_a[1], 8'h34);
    chk("in_mem2", mem_a[2], 8'hA5);
    chk("in_addr3", ifa.ld_addr, 3);
    chk("in_addr3_b", ifb.ld_addr, 3);
    chk("in_chksum", chk_a, CHK_LOAD);

    press(1'b1, 1'b0, 8);
    chk("ck_state", st_a, 2);
    chk("ck_addr0", ifa.ld_addr, 0);
    chk("ck_re", ifa.ld_re, 1);
    chk("ck_disp0", disp_a, 8'h12);
    press(1'b0, 1'b1, 8);
    chk("ck_addr1", ifa.ld_addr, 1);
    chk("ck_disp1", disp_a, 8'h34);
    step_btn = 1'b1;
    tick(7);
    chk("ck_addr2", ifa.ld_addr, 2);
    chk("ck_disp_lat", disp_a, 8'h34);
    tick(1);
    chk("ck_disp2", disp_a, 8'hA5);
    step_btn = 1'b0;
    tick(12);
    chk("ck_no_we", wcnt_a, 3);
    chk("ck_chksum", chk_a, CHK_LOAD);

    press(1'b1, 1'b0, 8);
    chk("run_state", st_a, 3);
    chk("run_memsel", ifa.mem_sel, 0);
    chk("run_re", ifa.ld_re, 0);
    press(1'b0, 1'b1, 8);
    chk("run_step_addr", ifa.ld_addr, 2);
    chk("run_step_disp", disp_a, 8'hA5);
    chk("run_no_we", wcnt_a, 3);
    press(1'b1, 1'b0, 8);
    chk("ret_state", st_a, 0);
    chk("ret_memsel", ifa.mem_sel, 1);
    chk("ret_addr", ifa.ld_addr, 2);

    press(1'b1, 1'b0, 8);
    chk("db_in_state", st_a, 1);
    chk("db_in_addr", ifa.ld_addr, 0);
    chk("db_in_chksum", chk_a, 0);
    step_btn = 1'b1;
    tick(3);
    step_btn = 1'b0;
    tick(12);
    chk("glitch_we", wcnt_a, 3);
    chk("glitch_addr", ifa.ld_addr, 0);
    press(1'b1, 1'b1, 8);
    chk("simul_state", st_a, 2);
    chk("simul_we", wcnt_a, 3);
    chk("simul_addr", ifa.ld_addr, 0);
    press(1'b0, 1'b1, 20);
    chk("held_one", ifa.ld_addr, 1);

    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    chk("wrap_in_state", st_a, 1);
    chk("wrap_in_addr_b", ifb.ld_addr, 0);
    for (int i = 0; i < 17; i++) begin
      sw_data = 8'(i);
      press(1'b0, 1'b1, 8);
    end
    chk("wrap_addr_a", ifa.ld_addr, 17);
    chk("wrap_addr_b", ifb.ld_addr, 1);
    chk("wrap_wcnt", wcnt_a, 20);
    chk("wrap_mem_b0", mem_b[0], 8'h10);
    chk("wrap_chksum", chk_a, CHK_WRAP);

    sw_data  = 8'h5A;
    step_btn = 1'b1;
    tick(7);
    chk("rstwr_pre_we", ifa.ld_we, 1);
    reset = 1'b0;
    #1;
    chk("rstwr_we", ifa.ld_we, 0);
    chk("rstwr_state", st_a, 0);
    chk("rstwr_addr", ifa.ld_addr, 0);
    step_btn = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(12);
    chk("rstwr_dropped", wcnt_a, 20);
    chk("rstwr_idle", st_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
